// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFN opcodes, pipeline FSM states and the status flag bundle.
// Imported by the datapath ALU and by instruction decode.
package alu_pkg;

    localparam logic [5:0] ALUFN_CMPEQ = 6'b000011;
    localparam logic [5:0] ALUFN_CMPLT = 6'b000101;
    localparam logic [5:0] ALUFN_CMPLE = 6'b000111;
    localparam logic [5:0] ALUFN_ADD   = 6'b010000;
    localparam logic [5:0] ALUFN_SUB   = 6'b010001;
    localparam logic [5:0] ALUFN_MUL   = 6'b010010;
    localparam logic [5:0] ALUFN_AND   = 6'b101000;
    localparam logic [5:0] ALUFN_OR    = 6'b101110;
    localparam logic [5:0] ALUFN_XOR   = 6'b100110;
    localparam logic [5:0] ALUFN_XNOR  = 6'b101001;
    localparam logic [5:0] ALUFN_A     = 6'b101010;
    localparam logic [5:0] ALUFN_SHL   = 6'b100000;
    localparam logic [5:0] ALUFN_SHR   = 6'b100001;
    localparam logic [5:0] ALUFN_SRA   = 6'b100011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic logic alufn_legal(input logic [5:0] fn);
        logic legal_s;
        case (fn)
            ALUFN_CMPEQ, ALUFN_CMPLT, ALUFN_CMPLE, ALUFN_ADD, ALUFN_SUB,
            ALUFN_MUL, ALUFN_AND, ALUFN_OR, ALUFN_XOR, ALUFN_XNOR,
            ALUFN_A, ALUFN_SHL, ALUFN_SHR, ALUFN_SRA: legal_s = 1'b1;
            default:                                   legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done pulses combinationally during the final step, with product carrying that step's sum.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      count_r;
    logic               busy_r;
    logic [2*WIDTH-1:0] acc_nx_s;
    logic               last_s;

    // Next accumulator value and final-step detection
    always_comb begin
        acc_nx_s = acc_r;
        if (mplier_r[0]) begin
            acc_nx_s = acc_r + mcand_r;
        end else begin
            acc_nx_s = acc_r;
        end
        last_s = busy_r && (count_r == CW'(WIDTH - 1));
    end

    // Multiplier datapath and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            count_r  <= {CW{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= mcand_r << 1'b1;
            mplier_r <= mplier_r >> 1'b1;
            count_r  <= count_r + CW'(1'b1);
            busy_r   <= !last_s;
        end
    end

    assign done    = last_s;
    assign product = acc_nx_s;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked datapath ALU: single-cycle ops land in the output register one cycle after
// accept; MUL runs through the iterative multiplier and blocks new requests while busy.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alufn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t         state_r;
    alu_state_t         state_nx_s;
    logic               out_valid_r;
    logic [WIDTH-1:0]   y_r;
    alu_flags_t         flags_r;
    logic               err_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               is_mul_s;
    logic               mul_start_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] product_s;
    alu_flags_t         mul_flags_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [SHW-1:0]     amt_s;
    logic               eq_s;
    logic               lt_s;
    logic [WIDTH-1:0]   res_s;
    alu_flags_t         res_flags_s;
    logic               res_err_s;

    assign in_ready_s  = !rst && (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign accept_s    = in_valid && in_ready_s;
    assign is_mul_s    = (alufn == ALUFN_MUL);
    assign mul_start_s = accept_s && is_mul_s;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (product_s)
    );

    // Single-cycle result and flags; carry/borrow come from the extra top bit
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        amt_s  = b[SHW-1:0];
        eq_s   = (a == b);
        if (SIGNED_CMP) begin
            lt_s = ($signed(a) < $signed(b));
        end else begin
            lt_s = (a < b);
        end
        res_s       = {WIDTH{1'b0}};
        res_flags_s = alu_flags_t'(4'b0000);
        res_err_s   = !alufn_legal(alufn);
        case (alufn)
            ALUFN_CMPEQ: res_s = {{(WIDTH-1){1'b0}}, eq_s};
            ALUFN_CMPLT: res_s = {{(WIDTH-1){1'b0}}, lt_s};
            ALUFN_CMPLE: res_s = {{(WIDTH-1){1'b0}}, lt_s | eq_s};
            ALUFN_ADD: begin
                res_s         = sum_s[WIDTH-1:0];
                res_flags_s.c = sum_s[WIDTH];
                res_flags_s.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALUFN_SUB: begin
                res_s         = diff_s[WIDTH-1:0];
                res_flags_s.c = diff_s[WIDTH];
                res_flags_s.v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALUFN_AND:  res_s = a & b;
            ALUFN_OR:   res_s = a | b;
            ALUFN_XOR:  res_s = a ^ b;
            ALUFN_XNOR: res_s = ~(a ^ b);
            ALUFN_A:    res_s = a;
            ALUFN_SHL:  res_s = a << amt_s;
            ALUFN_SHR:  res_s = a >> amt_s;
            ALUFN_SRA:  res_s = $unsigned($signed(a) >>> amt_s);
            default:    res_s = {WIDTH{1'b0}};
        endcase
        res_flags_s.z = (res_s == {WIDTH{1'b0}});
        res_flags_s.n = res_s[WIDTH-1];
    end

    // Flags for a finished multiply; overflow means the high half is nonzero
    always_comb begin
        mul_flags_s   = alu_flags_t'(4'b0000);
        mul_flags_s.z = (product_s[WIDTH-1:0] == {WIDTH{1'b0}});
        mul_flags_s.n = product_s[WIDTH-1];
        mul_flags_s.c = 1'b0;
        mul_flags_s.v = |product_s[2*WIDTH-1:WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start_s) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output register: a new result loads over a drain; otherwise hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= {WIDTH{1'b0}};
            flags_r     <= alu_flags_t'(4'b0000);
            err_r       <= 1'b0;
        end else if (mul_done_s) begin
            out_valid_r <= 1'b1;
            y_r         <= product_s[WIDTH-1:0];
            flags_r     <= mul_flags_s;
            err_r       <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            out_valid_r <= 1'b1;
            y_r         <= res_s;
            flags_r     <= res_flags_s;
            err_r       <= res_err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign flag_z    = flags_r.z;
    assign flag_n    = flags_r.n;
    assign flag_c    = flags_r.c;
    assign flag_v    = flags_r.v;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed vector table, MUL latency/reset sequences,
// backpressure, and randomized traffic scored against an arithmetic reference model.
module tb_alu_pipe;

    localparam logic [5:0] OP_CMPEQ = 6'b000011;
    localparam logic [5:0] OP_CMPLT = 6'b000101;
    localparam logic [5:0] OP_CMPLE = 6'b000111;
    localparam logic [5:0] OP_ADD   = 6'b010000;
    localparam logic [5:0] OP_SUB   = 6'b010001;
    localparam logic [5:0] OP_MUL   = 6'b010010;
    localparam logic [5:0] OP_AND   = 6'b101000;
    localparam logic [5:0] OP_OR    = 6'b101110;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_XNOR  = 6'b101001;
    localparam logic [5:0] OP_A     = 6'b101010;
    localparam logic [5:0] OP_SHL   = 6'b100000;
    localparam logic [5:0] OP_SHR   = 6'b100001;
    localparam logic [5:0] OP_SRA   = 6'b100011;
    localparam logic [5:0] OPS [14] = '{OP_CMPEQ, OP_CMPLT, OP_CMPLE, OP_ADD, OP_SUB, OP_MUL,
                                        OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_A, OP_SHL, OP_SHR, OP_SRA};

    // fl = {z, n, c, v, err}; ys is the result of the SIGNED_CMP=1 instance
    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [31:0] ys;
        logic [4:0]  fl;
    } vec_t;

    typedef struct packed {
        logic [31:0] y;
        logic [31:0] ys;
        logic [4:0]  fl;
    } exp_t;

    logic        clk, rst, in_valid, out_ready;
    logic [5:0]  alufn;
    logic [31:0] a_i, b_i;
    logic        in_ready0, out_valid0, z0, n0, c0, v0, err0;
    logic [31:0] y0;
    logic        in_ready1, out_valid1, z1, n1, c1, v1, err1;
    logic [31:0] y1;

    int   checks, errors, pops;
    exp_t q[$];
    vec_t vec[19];
    bit   done_drv;

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .alufn(alufn),
        .a(a_i), .b(b_i), .out_valid(out_valid0), .out_ready(out_ready), .y(y0),
        .flag_z(z0), .flag_n(n0), .flag_c(c0), .flag_v(v0), .err(err0));

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .alufn(alufn),
        .a(a_i), .b(b_i), .out_valid(out_valid1), .out_ready(out_ready), .y(y1),
        .flag_z(z1), .flag_n(n1), .flag_c(c1), .flag_v(v1), .err(err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] ia, input logic [31:0] ib);
        exp_t            e;
        longint          sa, sb, r;
        longint unsigned ua, ub, p;
        int              amt;
        logic [31:0]     yy, ys;
        logic            c, v, er, is_cmp;
        ua = 64'(ia); ub = 64'(ib);
        sa = longint'($signed(ia)); sb = longint'($signed(ib));
        amt = int'(ib[4:0]);
        yy = 32'h0; ys = 32'h0; c = 1'b0; v = 1'b0; er = 1'b0; is_cmp = 1'b0;
        case (op)
            OP_ADD: begin
                p = ua + ub; yy = p[31:0]; c = (p > 64'd4294967295);
                r = sa + sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            OP_SUB: begin
                p = ua - ub; yy = p[31:0]; c = (ua < ub);
                r = sa - sb; v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            OP_MUL: begin p = ua * ub; yy = p[31:0]; v = (p > 64'd4294967295); end
            OP_CMPEQ: begin is_cmp = 1'b1; yy = {31'h0, ua == ub}; ys = yy; end
            OP_CMPLT: begin is_cmp = 1'b1; yy = {31'h0, ua < ub};  ys = {31'h0, sa < sb}; end
            OP_CMPLE: begin is_cmp = 1'b1; yy = {31'h0, ua <= ub}; ys = {31'h0, sa <= sb}; end
            OP_AND:  yy = ia & ib;
            OP_OR:   yy = ia | ib;
            OP_XOR:  yy = ia ^ ib;
            OP_XNOR: yy = ~(ia ^ ib);
            OP_A:    yy = ia;
            OP_SHL:  yy = ia << amt;
            OP_SHR:  yy = ia >> amt;
            OP_SRA:  begin r = sa >>> amt; yy = r[31:0]; end
            default: er = 1'b1;
        endcase
        if (!is_cmp) ys = yy;
        e.y = yy; e.ys = ys;
        e.fl = {yy == 32'h0, yy[31], c, v, er};
        return e;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    // Call at posedge+1; returns at posedge+1 of the cycle after the accept edge
    task automatic apply_op(input logic [5:0] op, input logic [31:0] ia, input logic [31:0] ib);
        int n;
        in_valid = 1'b1; alufn = op; a_i = ia; b_i = ib;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("accept_timeout", in_ready0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: expectations enter on accept, leave on drain; held outputs must not move
    task automatic monitor();
        exp_t        e;
        logic        hold;
        logic [31:0] hy;
        logic [4:0]  hf;
        hold = 1'b0; hy = 32'h0; hf = 5'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", out_valid0, 1'b1);
                    chk("hold_y", y0, hy);
                    chk("hold_flags", {z0, n0, c0, v0, err0}, hf);
                end
                if (out_valid0 && out_ready) begin
                    if (q.size() == 0) begin
                        chk("sb_unexpected_out", out_valid0, 1'b0);
                    end else begin
                        e = q.pop_front();
                        pops++;
                        chk("sb_y", y0, e.y);
                        chk("sb_flags", {z0, n0, c0, v0, err0}, e.fl);
                        chk("sb_signed_valid", out_valid1, 1'b1);
                        chk("sb_signed_y", y1, e.ys);
                    end
                end
                if (in_valid && in_ready0) q.push_back(model(alufn, a_i, b_i));
                hold = out_valid0 && !out_ready;
                hy = y0;
                hf = {z0, n0, c0, v0, err0};
            end
        end
    endtask

    initial begin
        int n, bad, p0;
        logic [5:0] rop;
        checks = 0; errors = 0; pops = 0;
        rst = 1'b1; in_valid = 1'b0; alufn = 6'h0; a_i = 32'h0; b_i = 32'h0; out_ready = 1'b1;

        vec[0]  = {OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 5'b01010};
        vec[1]  = {OP_SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFE, 5'b01100};
        vec[2]  = {OP_CMPLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 5'b10000};
        vec[3]  = {OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 32'hF8000000, 5'b01000};
        vec[4]  = {OP_SHR,   32'h80000000, 32'h00000024, 32'h08000000, 32'h08000000, 5'b00000};
        vec[5]  = {6'b111111, 32'h00001234, 32'h00005678, 32'h00000000, 32'h00000000, 5'b10001};
        vec[6]  = {OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF000F000, 5'b01000};
        vec[7]  = {OP_OR,    32'h0F0F0000, 32'h00000F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 5'b00000};
        vec[8]  = {OP_XOR,   32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 32'h55555555, 5'b00000};
        vec[9]  = {OP_XNOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b01000};
        vec[10] = {OP_A,     32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 5'b00000};
        vec[11] = {OP_SHL,   32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 5'b01000};
        vec[12] = {OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 5'b10100};
        vec[13] = {OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'b00010};
        vec[14] = {OP_CMPLE, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000001, 5'b10000};
        vec[15] = {OP_CMPEQ, 32'h00000005, 32'h00000005, 32'h00000001, 32'h00000001, 5'b00000};
        vec[16] = {OP_CMPLE, 32'h00000005, 32'h00000005, 32'h00000001, 32'h00000001, 5'b00000};
        vec[17] = {OP_CMPLT, 32'h00000007, 32'h00000007, 32'h00000000, 32'h00000000, 5'b10000};
        vec[18] = {OP_ADD,   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 5'b10000};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready0, 1'b0);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_y", y0, 32'h0);
        chk("rst_flags", {z0, n0, c0, v0, err0}, 5'b00000);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready0, 1'b1);
        @(posedge clk); #1;

        // Directed table, result expected exactly one cycle after accept
        for (int i = 0; i < 19; i++) begin
            apply_op(vec[i].op, vec[i].a, vec[i].b);
            @(negedge clk);
            chk($sformatf("vec%0d_latency", i), out_valid0, 1'b1);
            chk($sformatf("vec%0d_y", i), y0, vec[i].y);
            chk($sformatf("vec%0d_ys", i), y1, vec[i].ys);
            chk($sformatf("vec%0d_flags", i), {z0, n0, c0, v0, err0}, vec[i].fl);
            @(posedge clk); #1;
        end

        // MUL latency: in_ready low t+1..t+32, result at t+33
        apply_op(OP_MUL, 32'h00010000, 32'h00010001);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (!in_ready0 && !out_valid0) bad++;
        end
        chk("mul_busy_cycles", bad, 32);
        @(negedge clk);
        chk("mul_out_valid", out_valid0, 1'b1);
        chk("mul_y", y0, 32'h00010000);
        chk("mul_flags", {z0, n0, c0, v0, err0}, 5'b00010);
        chk("mul_in_ready_back", in_ready0, 1'b1);
        @(posedge clk); #1;

        // Reset at t+10 of a MUL abandons it
        apply_op(OP_MUL, 32'h00000003, 32'h00000007);
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        chk("mul_rst_in_ready", in_ready0, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mul_rst_idle", in_ready0, 1'b1);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid0) bad++;
            @(negedge clk);
        end
        chk("mul_rst_no_result", bad, 0);
        @(posedge clk); #1;

        // Backpressure: four ADDs, first result held for three cycles
        out_ready = 1'b0;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 4; i++) apply_op(OP_ADD, 32'(i) * 32'h11111111, 32'h01010101 + 32'(i));
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid0 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_result", out_valid0, 1'b1);
                repeat (3) @(posedge clk);
                #1; out_ready = 1'b1;
            end
        join
        n = 0;
        while ((pops - p0) < 4 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp_all_results", pops - p0, 4);
        @(posedge clk); #1;

        // Random traffic with random consumer stalls
        done_drv = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 9) == 0) rop = 6'($urandom_range(0, 63));
                    else rop = OPS[$urandom_range(0, 13)];
                    apply_op(rop, rnd_operand(), rnd_operand());
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done_drv = 1'b1;
            end
            begin
                while (!done_drv) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while ((q.size() != 0 || out_valid0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        chk("rand_pop_count", pops - p0, 154);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
